// File: rtl/mdr_fill_ctrl.sv
// mdr_fill_ctrl
// Fetch-side sequencer for the 68-bit memory data register (MDR).
// It accepts a fetch request and issues one instruction-memory read. The
// returned word is written into the MDR and read back out. The word is then
// offered to decode under a valid/ready handshake.
//
// Optional feature macro: FETCH_TIMEOUT_EN
//   When it is defined, the WAIT state is bounded by TIMEOUT cycles.
//   Expiry pulses fetch_err and abandons the fetch.
//   When it is undefined, WAIT is unbounded, fetch_err is tied low and no
//   counter is built.

module mdr_fill_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 68,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_ack,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rvalid,
    output logic              MDR_wr,
    output logic              MDR_rd,
    output logic [DATA_W-1:0] instin,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic              busy,
    output logic              fetch_err
);

    // A zero timeout would abort before memory could ever answer.
    generate
        if (TIMEOUT < 1) begin : g_bad_timeout
            $error("mdr_fill_ctrl: TIMEOUT must be >= 1");
        end
    endgenerate

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_WRITE = 3'd3,
        ST_READ  = 3'd4,
        ST_VALID = 3'd5
    } state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
    logic [DATA_W-1:0] instin_reg, instin_next;

`ifdef FETCH_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] wait_cnt_reg, wait_cnt_next;
    logic             fetch_err_reg, fetch_err_next;
`endif

    // State and data registers; reset returns to IDLE and clears the captured data.
    // The MDR itself is outside this block and keeps its contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            mem_addr_reg <= '0;
            instin_reg   <= '0;
        end else begin
            state_reg    <= state_next;
            mem_addr_reg <= mem_addr_next;
            instin_reg   <= instin_next;
        end
    end

`ifdef FETCH_TIMEOUT_EN
    // Wait-cycle counter and the registered one-cycle error pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt_reg  <= '0;
            fetch_err_reg <= 1'b0;
        end else begin
            wait_cnt_reg  <= wait_cnt_next;
            fetch_err_reg <= fetch_err_next;
        end
    end
`endif

    // Next-state and data-capture logic; every target defaults to "hold".
    always_comb begin
        state_next    = state_reg;
        mem_addr_next = mem_addr_reg;
        instin_next   = instin_reg;
`ifdef FETCH_TIMEOUT_EN
        wait_cnt_next  = wait_cnt_reg;
        fetch_err_next = 1'b0;
`endif
        case (state_reg)
            ST_IDLE: begin
                if (fetch_req) begin
                    mem_addr_next = fetch_addr;
                    state_next    = ST_REQ;
                end
            end
            ST_REQ: begin
                // The single read strobe goes out in this state; the counter starts fresh for WAIT.
`ifdef FETCH_TIMEOUT_EN
                wait_cnt_next = '0;
`endif
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                // Memory data wins over an expiring timeout in the same cycle.
                if (mem_rvalid) begin
                    instin_next = mem_rdata;
                    state_next  = ST_WRITE;
                end
`ifdef FETCH_TIMEOUT_EN
                else if (wait_cnt_reg + CNT_W'(1) == TIMEOUT_CNT) begin
                    fetch_err_next = 1'b1;
                    state_next     = ST_IDLE;
                end else begin
                    wait_cnt_next = wait_cnt_reg + CNT_W'(1);
                end
`endif
            end
            ST_WRITE: begin
                state_next = ST_READ;
            end
            ST_READ: begin
                state_next = ST_VALID;
            end
            ST_VALID: begin
                if (inst_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Outputs decode the registered state only. The one exception is the
    // accept pulse, which by design mirrors fetch_req while idle. It is held
    // low during reset.
    assign fetch_ack  = ~rst & fetch_req & (state_reg == ST_IDLE);
    assign mem_rd_en  = (state_reg == ST_REQ);
    // WRITE and READ are distinct states, so MDR_wr and MDR_rd cannot overlap.
    assign MDR_wr     = (state_reg == ST_WRITE);
    assign MDR_rd     = (state_reg == ST_READ);
    assign inst_valid = (state_reg == ST_VALID);
    assign busy       = (state_reg != ST_IDLE);
    assign mem_addr   = mem_addr_reg;
    assign instin     = instin_reg;

`ifdef FETCH_TIMEOUT_EN
    assign fetch_err = fetch_err_reg;
`else
    assign fetch_err = 1'b0;
`endif

endmodule

// File: tb/tb_mdr_fill_ctrl.sv
// tb_mdr_fill_ctrl
// Randomised self-checking bench for mdr_fill_ctrl. Each fetch is described
// by its memory delay d and its decode stall r. The expected per-cycle
// strobes, captured word and latched address are derived from the
// transaction timeline relative to the accept cycle. Build with
// FETCH_TIMEOUT_EN defined to also cover the timeout path (TIMEOUT=3).

module tb_mdr_fill_ctrl;

    localparam int AW = 32;
    localparam int DW = 68;
    localparam int TB_TIMEOUT = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          fetch_req;
    logic [AW-1:0] fetch_addr;
    logic          fetch_ack;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata;
    logic          mem_rvalid;
    logic          mdr_wr;
    logic          mdr_rd;
    logic [DW-1:0] instin;
    logic          inst_valid;
    logic          inst_ready;
    logic          busy;
    logic          fetch_err;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc_cnt  = 0;
    int ack_cyc  = -1;
    int txn_id   = 0;

    // Reference-model state: the last latched address and the last captured word.
    logic [AW-1:0] exp_addr   = '0;
    logic [DW-1:0] exp_instin = '0;

    mdr_fill_ctrl #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TB_TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .fetch_req  (fetch_req),
        .fetch_addr (fetch_addr),
        .fetch_ack  (fetch_ack),
        .mem_rd_en  (mem_rd_en),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .mem_rvalid (mem_rvalid),
        .MDR_wr     (mdr_wr),
        .MDR_rd     (mdr_rd),
        .instin     (instin),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .busy       (busy),
        .fetch_err  (fetch_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_word();
        logic [95:0] tmp;
        tmp = {$urandom, $urandom, $urandom};
        return tmp[DW-1:0];
    endfunction

    function automatic logic [6:0] out_vec();
        return {fetch_ack, mem_rd_en, mdr_wr, mdr_rd, inst_valid, busy, fetch_err};
    endfunction

    // Compare the whole visible state at one sample point.
    task automatic check_cycle(input string tag, input logic [6:0] exp_v);
        check_eq({tag, ".strobes"}, 96'(out_vec()), 96'(exp_v));
        check_eq({tag, ".instin"}, 96'(instin), 96'(exp_instin));
        check_eq({tag, ".mem_addr"}, 96'(mem_addr), 96'(exp_addr));
    endtask

    task automatic next_cycle();
        @(posedge clk);
        cyc_cnt++;
        #1;
    endtask

    // Idle cycles: no request, and memory noise that must be ignored.
    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            fetch_req  = 1'b0;
            fetch_addr = $urandom;
            mem_rvalid = 1'($urandom_range(0, 1));
            mem_rdata  = rand_word();
            inst_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            check_cycle($sformatf("idle@%0d", cyc_cnt), 7'b0);
            next_cycle();
        end
    endtask

    // One fetch. Cycle 0 is the accept cycle. Memory answers d WAIT cycles
    // late, and decode stalls r VALID cycles. A fetch times out if d reaches
    // TIMEOUT in a timeout build.
    task automatic run_fetch(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                             input int d, input int r, input bit req_in_valid);
        bit         tmo;
        int         last;
        logic [6:0] exp_v;
        tmo = 1'b0;
`ifdef FETCH_TIMEOUT_EN
        tmo = (d >= TB_TIMEOUT);
`endif
        last = tmo ? 2 + TB_TIMEOUT : 5 + d + r;
        for (int c = 0; c <= last; c++) begin
            fetch_req  = (c == 0) || (req_in_valid && !tmo && c >= 5 + d);
            fetch_addr = (c == 0) ? addr : $urandom;
            mem_rdata  = rand_word();
            if (!tmo && c == 2 + d) begin
                mem_rvalid = 1'b1;
                mem_rdata  = data;
            end else if (c >= 2 && (tmo ? c <= 1 + TB_TIMEOUT : c < 2 + d)) begin
                mem_rvalid = 1'b0;
            end else begin
                mem_rvalid = 1'($urandom_range(0, 1));
            end
            if (!tmo && c >= 5 + d)
                inst_ready = (c >= 5 + d + r);
            else
                inst_ready = 1'($urandom_range(0, 1));
            if (c == 1) exp_addr = addr;
            if (!tmo && c == 3 + d) exp_instin = data;
            exp_v = {c == 0,
                     c == 1,
                     !tmo && c == 3 + d,
                     !tmo && c == 4 + d,
                     !tmo && c >= 5 + d && c <= 5 + d + r,
                     c >= 1 && (!tmo || c <= 1 + TB_TIMEOUT),
                     tmo && c == last};
            @(negedge clk);
            if (c == 0) ack_cyc = fetch_ack ? cyc_cnt : -1;
            check_cycle($sformatf("txn%0d.c%0d", txn_id, c), exp_v);
            next_cycle();
        end
        $display("txn %0d addr=0x%08h d=%0d r=%0d timeout=%0d checks=%0d failures=%0d",
                 txn_id, addr, d, r, tmo, n_checks, n_fail);
        txn_id++;
    endtask

    initial begin
        int a1;
        int a2;
        logic [AW-1:0] ra;

        rst        = 1'b1;
        fetch_req  = 1'b0;
        fetch_addr = '0;
        mem_rdata  = '0;
        mem_rvalid = 1'b0;
        inst_ready = 1'b0;
        #2;
        check_cycle("reset", 7'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        idle_cycles(2);

        // Single fetch with zero memory wait and decode ready.
        run_fetch(32'h0000_0040, 68'hA_1234_5678_9ABC_DEF0, 0, 0, 1'b0);
        idle_cycles(1);

        // Four-cycle memory wait.
        run_fetch(32'h0000_0040, rand_word(), 4, 0, 1'b0);
        idle_cycles(1);

        // Decode backpressure for 3 cycles; a request raised in VALID is held into IDLE.
        run_fetch(32'h0000_0048, rand_word(), 1, 3, 1'b1);
        run_fetch(32'h0000_004C, rand_word(), 0, 0, 1'b0);
        idle_cycles(1);

        // Asynchronous reset while waiting on memory.
        fetch_req  = 1'b1;
        fetch_addr = 32'h0000_0080;
        next_cycle();
        fetch_req = 1'b0;
        next_cycle();
        next_cycle();
        rst = 1'b1;
        #1;
        exp_addr   = '0;
        exp_instin = '0;
        check_cycle("rst_in_wait", 7'b0);
        next_cycle();
        rst        = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = rand_word();
        @(negedge clk);
        check_cycle("late_rvalid", 7'b0);
        next_cycle();
        idle_cycles(3);
        run_fetch(32'h0000_0090, rand_word(), 2, 1, 1'b0);
        idle_cycles(1);

`ifdef FETCH_TIMEOUT_EN
        // Memory never answers, then answers on the last permitted WAIT cycle.
        run_fetch(32'h0000_0100, rand_word(), 99, 0, 1'b0);
        idle_cycles(1);
        run_fetch(32'h0000_0104, rand_word(), TB_TIMEOUT - 1, 0, 1'b0);
        idle_cycles(1);
`endif

        // Back-to-back fetches: the second accept comes six cycles after the first.
        run_fetch(32'h0000_0040, rand_word(), 0, 0, 1'b0);
        a1 = ack_cyc;
        run_fetch(32'h0000_0044, rand_word(), 0, 0, 1'b0);
        a2 = ack_cyc;
        check_eq("b2b_gap", 96'(a2 - a1), 96'(6));
        idle_cycles(1);

        // Randomised fetches with random memory delay, stall, held requests and gaps.
        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            ra[1:0] = 2'b00;
            run_fetch(ra, rand_word(), $urandom_range(0, 5), $urandom_range(0, 3),
                      1'($urandom_range(0, 1)));
            idle_cycles($urandom_range(0, 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
